transmitter: RTL

UART serial transmitter: accepts parallel bytes over a valid/ready handshake and drives them onto the serial line as 8N1-style frames (optionally with parity and two stop bits). It sits directly upstream of `receiver`: its `data` output is the line `receiver` samples, and it is paced by the same bit-rate strobe `baud` produced by `baudUnit`. A one-entry holding register allows the next byte to be accepted while the current frame shifts out, so frames go back-to-back with no idle gap.

---
 rtl/transmitter_if.sv | 24 ++
 rtl/transmitter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/transmitter_if.sv
// Byte handshake between a producer and the UART transmitter.
//   tx_data  : byte to send, sampled on accept
//   tx_valid : tx_data is valid
//   tx_ready : transmitter holding register is empty
// An accept happens on a rising edge where tx_valid && tx_ready.
interface transmitter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/transmitter.sv
// UART serial transmitter. Takes bytes over a valid/ready handshake into a
// one-entry holding register and shifts them out LSB first as frames of
// START, WIDTH data bits, optional parity, and STOP_BITS stop bits. Every
// bit lasts one baud strobe period. A byte that is waiting when the last
// stop bit ends starts on that same strobe, so frames run back-to-back.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   baud       : one-cycle strobe per bit period
//   tx         : byte handshake (slave side)
//   data       : serial line, idle high
//   busy       : high from START through the last STOP bit
//   frame_done : one-cycle pulse after the last stop bit ends
module transmitter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         baud,
    transmitter_if.slave tx,
    output logic         data,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   hold_q;
    logic               hold_empty_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_d;
    logic               par_q;
    logic               par_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic               stop_cnt_q;
    logic               stop_cnt_d;
    logic               data_d;
    logic               busy_d;
    logic               frame_done_d;
    logic               load_c;
    logic               last_bit_c;
    logic               last_stop_c;
    logic               odd_par_c;

    assign last_bit_c  = (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign last_stop_c = (stop_cnt_q == 1'(STOP_BITS - 1));
    assign odd_par_c   = (PARITY == 2);
    assign tx.tx_ready = hold_empty_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; load_c marks the strobe that moves the held byte into the shifter
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        if (baud) begin
            case (state_q)
                S_IDLE: begin
                    if (!hold_empty_q) begin
                        load_c  = 1'b1;
                        state_d = S_START;
                    end
                end
                S_START: state_d = S_DATA;
                S_DATA: begin
                    if (last_bit_c) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: state_d = S_STOP;
                S_STOP: begin
                    if (last_stop_c) begin
                        if (!hold_empty_q) begin
                            load_c  = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the line, status and shifter, all registered below
    always_comb begin
        shift_d      = shift_q;
        par_d        = par_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        data_d       = data;
        busy_d       = busy;
        frame_done_d = 1'b0;
        if (baud) begin
            case (state_q)
                S_IDLE: data_d = 1'b1;
                S_START: begin
                    data_d     = shift_q[0];
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
                S_DATA: begin
                    if (last_bit_c) begin
                        data_d = (PARITY != 0) ? par_q : 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        data_d    = shift_d[0];
                    end
                end
                S_PARITY: data_d = 1'b1;
                S_STOP: begin
                    if (last_stop_c) begin
                        frame_done_d = 1'b1;
                        data_d       = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: data_d = 1'b1;
            endcase
            // Loading overrides the idle values: start bit goes out on this strobe
            if (load_c) begin
                shift_d = hold_q;
                par_d   = (^hold_q) ^ odd_par_c;
                data_d  = 1'b0;
                busy_d  = 1'b1;
            end
        end
    end

    // Datapath and registered outputs; accept and load are mutually exclusive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            shift_q      <= '0;
            par_q        <= 1'b0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            data         <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (load_c) begin
                hold_empty_q <= 1'b1;
            end else if (tx.tx_valid && hold_empty_q) begin
                hold_q       <= tx.tx_data;
                hold_empty_q <= 1'b0;
            end
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data       <= data_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

endmodule
